// File: rtl/qpp_pkg.sv
// Shared QPP types and arithmetic for the interleaver/deinterleaver pair.
// Holds the address width, default buffer depth, FSM states and the modular adder.
package qpp_pkg;

    localparam int AW        = 16;
    localparam int DEPTH_DEF = 6144;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Both operands are already reduced mod n, so one conditional subtract is enough.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                               input logic [AW-1:0] b,
                                               input logic [AW-1:0] n);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, n}) begin
            s = s - {1'b0, n};
        end
        return s[AW-1:0];
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// QPP address recursion: pi(i+1) = pi(i) + gamma(i), gamma(i+1) = gamma(i) + g, all mod N.
// pi_o is registered; init loads pi=0/gamma=gamma0, step advances one index per cycle.
module qpp_addr_gen
    import qpp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_i,
    input  logic          step_i,
    input  logic [AW-1:0] gamma0_i,
    input  logic [AW-1:0] g_i,
    input  logic [AW-1:0] n_i,
    output logic [AW-1:0] pi_o
);

    logic [AW-1:0] pi_q, pi_d;
    logic [AW-1:0] gamma_q, gamma_d;

    always_comb begin
        pi_d    = pi_q;
        gamma_d = gamma_q;
        if (init_i) begin
            pi_d    = '0;
            gamma_d = gamma0_i;
        end else if (step_i) begin
            pi_d    = mod_add(pi_q, gamma_q, n_i);
            gamma_d = mod_add(gamma_q, g_i, n_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_q    <= '0;
            gamma_q <= '0;
        end else begin
            pi_q    <= pi_d;
            gamma_q <= gamma_d;
        end
    end

    assign pi_o = pi_q;

endmodule

// File: rtl/qpp_deinterleaver.sv
// Buffered QPP deinterleaver: writes symbol i to mem[pi(i)], then streams mem[0..N-1] out.
// First output 2 cycles after the last input; output register holds data while out_ready is low.
module qpp_deinterleaver
    import qpp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     n_len,
    input  logic [AW-1:0]     gamma0,
    input  logic [AW-1:0]     g,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [AW-1:0]     n_q, n_d;
    logic [AW-1:0]     g_q, g_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rd_dat_q;

    logic              cfg_bad;
    logic              ag_init;
    logic              wr_en;
    logic              rd_en;
    logic              out_hs;
    logic [AW-1:0]     pi;
    logic              unused_addr_hi;

    logic [DATA_W-1:0] mem [DEPTH];

    assign cfg_bad = (n_len == '0) || (n_len > AW'(DEPTH)) ||
                     (gamma0 >= n_len) || (g >= n_len);
    assign out_hs  = vld_q && out_ready;

    qpp_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_i   (ag_init),
        .step_i   (wr_en),
        .gamma0_i (gamma0),
        .g_i      (g_q),
        .n_i      (n_q),
        .pi_o     (pi)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        g_d       = g_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        err_d     = err_q;
        done_d    = 1'b0;
        vld_d     = vld_q;
        last_d    = last_q;
        ag_init   = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        n_d     = n_len;
                        g_d     = g;
                        cnt_d   = '0;
                        ag_init = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == n_q - AW'(1)) begin
                        rd_addr_d = '0;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Prefetch the next word whenever the output register is empty or being consumed.
                rd_en = (rd_addr_q < n_q) && (!vld_q || out_ready);
                if (rd_en) begin
                    vld_d     = 1'b1;
                    last_d    = (rd_addr_q == n_q - AW'(1));
                    rd_addr_d = rd_addr_q + AW'(1);
                end else if (out_hs) begin
                    vld_d  = 1'b0;
                    last_d = 1'b0;
                end
                if (out_hs && last_q) begin
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            g_q       <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            g_q       <= g_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
            done_q    <= done_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[pi[MW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else if (rd_en) begin
            rd_dat_q <= mem[rd_addr_q[MW-1:0]];
        end
    end

    // Addresses never reach DEPTH, so the high bits carry no information.
    assign unused_addr_hi = ^{pi[AW-1:MW], rd_addr_q[AW-1:MW]};

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign out_data  = rd_dat_q;
    assign out_valid = vld_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// Randomized bench for qpp_deinterleaver against a closed-form QPP model pi(i) = (f1*i + f2*i^2) mod N.
module tb_qpp_deinterleaver;

    localparam int DW  = 8;
    localparam int DEP = 6144;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   n_len = '0;
    logic [15:0]   gamma0 = '0;
    logic [15:0]   g = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    qpp_deinterleaver #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_len     (n_len),
        .gamma0    (gamma0),
        .g         (g),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] din  [DEP];
    logic [DW-1:0] dexp [DEP];
    logic [DW-1:0] orig [DEP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qpp_pi(input int i, input int n, input int f1, input int f2);
        longint t;
        t = (longint'(f1) * i + longint'(f2) * i * i) % n;
        return int'(t);
    endfunction

    task automatic start_block(input int n, input int g0, input int gg);
        @(negedge clk);
        start  = 1'b1;
        n_len  = 16'(n);
        gamma0 = 16'(g0);
        g      = 16'(gg);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic make_exp(input int n, input int f1, input int f2);
        for (int i = 0; i < n; i++) dexp[qpp_pi(i, n, f1, f2)] = din[i];
    endtask

    task automatic run_block(input int n, input int g0, input int gg, input bit gaps, input string tag);
        int i, k, budget, t_last_in, t_first_out, t_last_out;
        bit stalled;
        logic [DW-1:0] held;
        start_block(n, g0, gg);
        check({tag, "_in_ready_after_start"}, in_ready, 1);
        check({tag, "_err_clear"}, err, 0);
        check({tag, "_busy"}, busy, 1);
        i = 0; budget = 0; t_last_in = 0;
        while (i < n && budget < 20 * n + 100) begin
            in_valid = gaps ? ($urandom_range(0, 99) >= 30) : 1'b1;
            in_data  = din[i];
            if (in_valid && in_ready) begin
                i++;
                t_last_in = cyc;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        check({tag, "_load_count"}, i, n);
        k = 0; budget = 0; stalled = 1'b0; held = '0;
        t_first_out = -1; t_last_out = 0;
        while (k < n && budget < 20 * n + 100) begin
            if (stalled) begin
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_data"}, out_data, held);
            end
            out_ready = gaps ? ($urandom_range(0, 99) >= 30) : 1'b1;
            stalled = 1'b0;
            if (out_valid) begin
                if (t_first_out < 0) t_first_out = cyc;
                if (out_ready) begin
                    check({tag, "_data"}, out_data, dexp[k]);
                    check({tag, "_last"}, out_last, (k == n - 1));
                    k++;
                    t_last_out = cyc;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        check({tag, "_drain_count"}, k, n);
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_valid_after"}, out_valid, 0);
        if (!gaps) begin
            check({tag, "_first_out_latency"}, t_first_out - t_last_in, 2);
            check({tag, "_throughput"}, t_last_out - t_first_out, n - 1);
        end
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    task automatic bad_start(input int n, input int g0, input int gg, input string tag);
        start_block(n, g0, gg);
        check({tag, "_err"}, err, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // N=40 f1=3 f2=10, ramp data
        for (int i = 0; i < 40; i++) din[i] = DW'(i);
        make_exp(40, 3, 10);
        run_block(40, 13, 20, 1'b0, "n40_ramp");

        // Full depth, random data
        for (int i = 0; i < 6144; i++) din[i] = DW'($urandom_range(0, 255));
        make_exp(6144, 263, 480);
        run_block(6144, 743, 960, 1'b0, "n6144");

        // Round trip: feed the QPP-interleaved sequence, expect the original back
        for (int i = 0; i < 40; i++) orig[i] = DW'($urandom_range(0, 255));
        for (int i = 0; i < 40; i++) din[i] = orig[qpp_pi(i, 40, 3, 10)];
        for (int i = 0; i < 40; i++) dexp[i] = orig[i];
        run_block(40, 13, 20, 1'b0, "roundtrip");

        // Random valid/ready gaps
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) din[i] = DW'($urandom_range(0, 255));
            make_exp(40, 3, 10);
            run_block(40, 13, 20, 1'b1, "gaps");
        end

        // N=1
        din[0] = DW'($urandom_range(0, 255));
        dexp[0] = din[0];
        run_block(1, 0, 0, 1'b0, "n1");

        // Config errors, then a valid start clears err
        bad_start(0, 0, 0, "cfg_n0");
        bad_start(7000, 13, 20, "cfg_n7000");
        bad_start(40, 50, 20, "cfg_gamma");
        for (int i = 0; i < 40; i++) din[i] = DW'($urandom_range(0, 255));
        make_exp(40, 3, 10);
        run_block(40, 13, 20, 1'b0, "after_err");

        // Reset in the middle of LOAD after 17 symbols; a stray start there must be ignored
        start_block(40, 13, 20);
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start  = 1'b1;
        n_len  = '0;
        @(negedge clk);
        start  = 1'b0;
        check("load_start_ignored_err", err, 0);
        check("load_start_ignored_ready", in_ready, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midload_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) din[i] = DW'($urandom_range(0, 255));
        make_exp(40, 3, 10);
        run_block(40, 13, 20, 1'b1, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
